ez8_pc_seq: RTL and testbench
=============================

// Module: ez8_pc_seq
// PURPOSE
//  Parametrised program-counter sequencer for the ez8 core family; successor to pc_ctrl.
//  Drives the fetch address into the synchronous instruction memory and applies goto/call/ret/skip.
//  Adds a configurable-depth return stack, a halt stop, and stack overflow/underflow errors.
//  Optional interrupt vectoring. Sits between decode/ALU and instr_mem in ez8_cpu.
// PARAMETERS
//  ADDR_W       12      fetch address width (instruction memory = 2**ADDR_W words)
//  STACK_DEPTH  8       return-stack entries (>=1)
//  RESET_VEC    0       pc_out value after reset
//  IRQ_VEC      4       interrupt target address (used only with EZ8_PC_IRQ_EN)
// PORTS
//  clk        in   1       sole clock, rising edge
//  reset      in   1       synchronous, ACTIVE-LOW reset
//  pause      in   1       freeze all state; outputs hold
//  goto       in   1       redirect to goto_addr (decoded from instr on mem q)
//  call       in   1       push return address, redirect to goto_addr
//  ret        in   1       pop return address, redirect to it
//  halt       in   1       stop fetching (sticky until reset)
//  skip       in   1       squash next instruction, no redirect (from ALU)
//  goto_addr  in   ADDR_W  target for goto/call
//  irq        in   1       interrupt request, level
//  gie        in   1       global interrupt enable
//  pc_out     out  ADDR_W  fetch address to instr_mem rdaddress
//  kill       out  1       instruction now on mem q must not commit
//  irq_ack    out  1       one-cycle pulse: interrupt taken
//  stopped    out  1       sticky: halted or error
//  error      out  1       sticky: stack overflow/underflow
//  depth      out  $clog2(STACK_DEPTH+1)  current stack occupancy
// BEHAVIOUR
//  Reset (reset==0 at edge): pc_out=RESET_VEC, kill=1, stack empty (depth=0), stopped=0, error=0, irq_ack=0.
//  Running cycle = !pause && !stopped. Pause/stopped: pc_out, stack, kill, depth frozen; irq_ack=0.
//  Instr at address A appears on q when pc_out==A+1 (1-cycle mem latency).
//  Control inputs are qualified by !kill: if kill==1, goto/call/ret/halt/skip/irq are ignored.
//  Priority per running cycle: halt > ret > call > goto > irq > skip > sequential.
//   sequential: pc_out<=pc_out+1 (mod 2**ADDR_W wrap, 4095->0 at default), kill<=0.
//   goto: pc_out<=goto_addr, kill<=1 (one cycle).
//   call: depth<STACK_DEPTH: push pc_out, pc_out<=goto_addr, kill<=1.
//         depth==STACK_DEPTH: overflow -> error<=1, stopped<=1, no push, pc_out holds.
//   ret: depth>0: pc_out<=top, pop, kill<=1. depth==0: underflow -> error<=1, stopped<=1.
//   halt: stopped<=1, pc_out holds; kill unchanged.
//   skip: pc_out<=pc_out+1, kill<=1 (squashes next instruction).
//  kill is registered; it is high exactly one cycle after each redirect/skip, never two in a row
//  from a single event (kill gates inputs, so back-to-back redirects cannot chain).
//  Push and pop never occur in the same cycle (priority rules).
//  Reset mid-operation overrides everything, including a pending kill or full stack.
// CONFIGURATION
//  `EZ8_PC_IRQ_EN defined: in a running cycle with irq && gie && !kill and no
//   halt/ret/call/goto: depth<STACK_DEPTH -> push pc_out-1 (interrupted instr, squashed),
//   pc_out<=IRQ_VEC, kill<=1, irq_ack<=1 for one cycle. Full stack -> overflow as for call.
//   gie clearing is owned by mem_ctrl on irq_ack.
//  Not defined: irq/gie ignored, irq_ack tied 0, IRQ_VEC unused.
// STRUCTURE
//  Package ez8_pkg: opcode constants (GOTO 3'b100, CALL 4'b1001, RET 4'b1101), default ADDR_W,
//   redirect-cause enum {SEQ, GOTO, CALL, RET, IRQ, SKIP, HALT}.
//  Sub-module ez8_ret_stack: LIFO, params WIDTH/DEPTH; push/pop/top/depth/full/empty; registered
//   array, combinational top; push-on-full and pop-on-empty are no-ops (parent flags error).
// TESTING
//  1 Reset release, straight-line: pc_out 0,1,2,3...; kill=1 first cycle only, then 0.
//  2 goto 0x123 at pc_out=0x006 -> next pc_out=0x123, kill=1 one cycle, a goto asserted during
//    that kill cycle is ignored.
//  3 Nested calls to depth 8 then 8 rets -> returns in LIFO order to each call addr+1; depth 8->0.
//  4 9th call with STACK_DEPTH=8 -> error=1, stopped=1, pc_out frozen; ret at depth 0 after reset
//    -> error=1.
//  5 skip at pc_out=0x010 -> pc_out 0x011, kill=1 next cycle; pause held 3 cycles mid-sequence ->
//    pc_out/kill unchanged, resumes exactly.
//  6 EZ8_PC_IRQ_EN: irq=gie=1 at pc_out=0x051 -> push 0x050, pc_out=0x004, irq_ack pulse; ret
//    -> pc_out=0x050. Without macro: irq ignored.

Source files
------------

// File: rtl/ez8_pkg.sv
// ============================================================================
//  Package  : ez8_pkg
//  Brief    : Shared constants and types for the ez8 program-counter sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ez8_pkg;

  localparam int EZ8_ADDR_W = 12;

  // Opcode prefixes decoded upstream into goto/call/ret strobes.
  localparam logic [2:0] OP_GOTO = 3'b100;
  localparam logic [3:0] OP_CALL = 4'b1001;
  localparam logic [3:0] OP_RET  = 4'b1101;

  typedef enum logic [2:0] {
    SEQ  = 3'd0,
    GOTO = 3'd1,
    CALL = 3'd2,
    RET  = 3'd3,
    IRQ  = 3'd4,
    SKIP = 3'd5,
    HALT = 3'd6
  } cause_e;

  // Fixed arbitration order: halt > ret > call > goto > irq > skip > sequential.
  function automatic cause_e pick_cause(input logic live, input logic halt,
                                        input logic ret, input logic call,
                                        input logic jump, input logic irq_req,
                                        input logic skip);
    cause_e c;
    c = SEQ;
    if (live) begin
      if (halt)         c = HALT;
      else if (ret)     c = RET;
      else if (call)    c = CALL;
      else if (jump)    c = GOTO;
      else if (irq_req) c = IRQ;
      else if (skip)    c = SKIP;
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ez8_ret_stack.sv
// ============================================================================
//  Module   : ez8_ret_stack
//  Brief    : Shift-register LIFO for return addresses; entry 0 is always top.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ez8_ret_stack
  import ez8_pkg::*;
#(
  parameter int WIDTH = EZ8_ADDR_W,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty
);

  localparam int DW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DW-1:0]    r_depth;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_depth == DW'(DEPTH));
  assign empty     = (r_depth == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty & ~push;

  // Storage is left unreset; only occupancy matters for correctness.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
    end else if (w_do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_depth <= '0;
    end else if (w_do_push) begin
      r_depth <= r_depth + DW'(1);
    end else if (w_do_pop) begin
      r_depth <= r_depth - DW'(1);
    end
  end

  assign top   = r_mem[0];
  assign depth = r_depth;

endmodule

`default_nettype wire

// File: rtl/ez8_pc_seq.sv
// ============================================================================
//  Module   : ez8_pc_seq
//  Brief    : Program-counter sequencer with return stack, halt and errors.
//             Interrupt vectoring is enabled by defining EZ8_PC_IRQ_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ez8_pc_seq
  import ez8_pkg::*;
#(
  parameter int ADDR_W      = EZ8_ADDR_W,
  parameter int STACK_DEPTH = 8,
  parameter int RESET_VEC   = 0,
  parameter int IRQ_VEC     = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pause,
  input  logic                               goto,
  input  logic                               call,
  input  logic                               ret,
  input  logic                               halt,
  input  logic                               skip,
  input  logic [ADDR_W-1:0]                  goto_addr,
  input  logic                               irq,
  input  logic                               gie,
  output logic [ADDR_W-1:0]                  pc_out,
  output logic                               kill,
  output logic                               irq_ack,
  output logic                               stopped,
  output logic                               error,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth
);

  localparam logic [ADDR_W-1:0] c_RESET_VEC = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] c_IRQ_VEC   = ADDR_W'(IRQ_VEC);

  logic [ADDR_W-1:0] r_pc;
  logic              r_kill;
  logic              r_stopped;
  logic              r_error;
  logic              r_irq_ack;

  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_kill_nxt;
  logic              w_stopped_nxt;
  logic              w_error_nxt;
  logic              w_ack_nxt;
  logic              w_run;
  logic              w_irq_req;
  cause_e            w_cause;

  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_push_data;
  logic [ADDR_W-1:0] w_top;
  logic              w_full;
  logic              w_empty;

`ifdef EZ8_PC_IRQ_EN
  assign w_irq_req = irq & gie;
`else
  logic w_unused_irq;
  assign w_irq_req    = 1'b0;
  assign w_unused_irq = irq ^ gie;
`endif

  assign w_run   = ~pause & ~r_stopped;
  assign w_cause = pick_cause(w_run & ~r_kill, halt, ret, call, goto, w_irq_req, skip);

  always_comb begin
    w_pc_nxt      = r_pc;
    w_kill_nxt    = r_kill;
    w_stopped_nxt = r_stopped;
    w_error_nxt   = r_error;
    w_ack_nxt     = 1'b0;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_push_data   = r_pc;
    if (w_run) begin
      unique case (w_cause)
        HALT: w_stopped_nxt = 1'b1;
        RET: begin
          if (!w_empty) begin
            w_pc_nxt   = w_top;
            w_pop      = 1'b1;
            w_kill_nxt = 1'b1;
          end else begin
            w_error_nxt   = 1'b1;
            w_stopped_nxt = 1'b1;
          end
        end
        // An interrupt resumes at the squashed instruction, i.e. pc_out-1.
        CALL, IRQ: begin
          if (!w_full) begin
            w_push      = 1'b1;
            w_push_data = (w_cause == IRQ) ? r_pc - ADDR_W'(1) : r_pc;
            w_pc_nxt    = (w_cause == IRQ) ? c_IRQ_VEC : goto_addr;
            w_kill_nxt  = 1'b1;
            w_ack_nxt   = (w_cause == IRQ);
          end else begin
            w_error_nxt   = 1'b1;
            w_stopped_nxt = 1'b1;
          end
        end
        GOTO: begin
          w_pc_nxt   = goto_addr;
          w_kill_nxt = 1'b1;
        end
        SKIP: begin
          w_pc_nxt   = r_pc + ADDR_W'(1);
          w_kill_nxt = 1'b1;
        end
        default: begin
          w_pc_nxt   = r_pc + ADDR_W'(1);
          w_kill_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc      <= c_RESET_VEC;
      r_kill    <= 1'b1;
      r_stopped <= 1'b0;
      r_error   <= 1'b0;
      r_irq_ack <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_kill    <= w_kill_nxt;
      r_stopped <= w_stopped_nxt;
      r_error   <= w_error_nxt;
      r_irq_ack <= w_ack_nxt;
    end
  end

  ez8_ret_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_push_data),
    .top   (w_top),
    .depth (depth),
    .full  (w_full),
    .empty (w_empty)
  );

  assign pc_out  = r_pc;
  assign kill    = r_kill;
  assign stopped = r_stopped;
  assign error   = r_error;
  assign irq_ack = r_irq_ack;

endmodule

`default_nettype wire

// File: tb/tb_ez8_pc_seq.sv
// Directed bench for ez8_pc_seq; expected states queued per step, popped after each edge.
`default_nettype none

module tb_ez8_pc_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pause = 1'b0, goto = 1'b0, call = 1'b0, ret = 1'b0;
  logic        halt = 1'b0, skip = 1'b0, irq = 1'b0, gie = 1'b0;
  logic [11:0] goto_addr = '0;
  logic [11:0] pc_out;
  logic        kill, irq_ack, stopped, error;
  logic [3:0]  depth;

  ez8_pc_seq dut (
    .clk       (clk),
    .reset     (reset),
    .pause     (pause),
    .goto      (goto),
    .call      (call),
    .ret       (ret),
    .halt      (halt),
    .skip      (skip),
    .goto_addr (goto_addr),
    .irq       (irq),
    .gie       (gie),
    .pc_out    (pc_out),
    .kill      (kill),
    .irq_ack   (irq_ack),
    .stopped   (stopped),
    .error     (error),
    .depth     (depth)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pc;
    logic        kill;
    logic        stopped;
    logic        error;
    logic [3:0]  depth;
    logic        ack;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          step = 0;
  logic [11:0] epc;
  logic [11:0] rets [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s@step%0d: observed %0h expected %0h", tag, step, obs, expv);
    end
  endtask

  // Queue the expected post-edge state, clock once, then compare.
  task automatic tick(input logic [11:0] p, input logic k, input logic st,
                      input logic er, input logic [3:0] d, input logic a);
    exp_t e;
    e.pc = p; e.kill = k; e.stopped = st; e.error = er; e.depth = d; e.ack = a;
    sb.push_back(e);
    @(posedge clk);
    #1;
    step++;
    e = sb.pop_front();
    chk("pc_out",  32'(pc_out),  32'(e.pc));
    chk("kill",    32'(kill),    32'(e.kill));
    chk("stopped", 32'(stopped), 32'(e.stopped));
    chk("error",   32'(error),   32'(e.error));
    chk("depth",   32'(depth),   32'(e.depth));
    chk("irq_ack", 32'(irq_ack), 32'(e.ack));
  endtask

  // Nested calls to full depth; call held through each kill cycle to show it is ignored.
  task automatic do_calls();
    for (int i = 0; i < 8; i++) begin
      rets[i]   = epc;
      call      = 1'b1;
      goto_addr = 12'(12'h300 + i * 12'h020);
      epc       = goto_addr;
      tick(epc, 1'b1, 1'b0, 1'b0, 4'(i + 1), 1'b0);
      epc = epc + 12'd1;
      tick(epc, 1'b0, 1'b0, 1'b0, 4'(i + 1), 1'b0);
      call = 1'b0;
    end
  endtask

  initial begin
    tick(12'h000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick(12'h000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

    // Straight-line fetch after reset release
    reset = 1'b1;
    epc   = 12'h000;
    for (int i = 0; i < 6; i++) begin
      epc = epc + 12'd1;
      tick(epc, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    end

    // goto; a second goto during the kill cycle is ignored
    goto = 1'b1; goto_addr = 12'h123;
    tick(12'h123, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    goto_addr = 12'h200;
    tick(12'h124, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    goto = 1'b0;
    epc  = 12'h124;

    do_calls();
    for (int j = 7; j >= 0; j--) begin
      ret = 1'b1;
      tick(rets[j], 1'b1, 1'b0, 1'b0, 4'(j), 1'b0);
      ret = 1'b0;
      tick(rets[j] + 12'd1, 1'b0, 1'b0, 1'b0, 4'(j), 1'b0);
    end

    // skip at 0x010; skip held into the kill cycle is ignored
    goto = 1'b1; goto_addr = 12'h00F;
    tick(12'h00F, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    goto = 1'b0;
    tick(12'h010, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    skip = 1'b1;
    tick(12'h011, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick(12'h012, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    skip = 1'b0;
    tick(12'h013, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

    // Pause over a kill cycle, with a goto presented that must be ignored
    goto = 1'b1; goto_addr = 12'h040;
    tick(12'h040, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    pause = 1'b1; goto_addr = 12'h7AA;
    for (int i = 0; i < 3; i++) tick(12'h040, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    pause = 1'b0; goto = 1'b0;
    tick(12'h041, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    pause = 1'b1;
    tick(12'h041, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    pause = 1'b0;
    tick(12'h042, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

    // Address wrap at the top of memory
    goto = 1'b1; goto_addr = 12'hFFE;
    tick(12'hFFE, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    goto = 1'b0;
    tick(12'hFFF, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    tick(12'h000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

    // Interrupt: irq without gie ignored in every build
    goto = 1'b1; goto_addr = 12'h04F;
    tick(12'h04F, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    goto = 1'b0;
    tick(12'h050, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    irq = 1'b1;
    tick(12'h051, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    gie = 1'b1;
`ifdef EZ8_PC_IRQ_EN
    tick(12'h004, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1);
    irq = 1'b0; gie = 1'b0;
    tick(12'h005, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    ret = 1'b1;
    tick(12'h050, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    ret = 1'b0;
    tick(12'h051, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    epc = 12'h051;
`else
    tick(12'h052, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    irq = 1'b0; gie = 1'b0;
    tick(12'h053, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    epc = 12'h053;
`endif

    // Halt is sticky; later redirects are ignored
    halt = 1'b1;
    tick(epc, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    halt = 1'b0; goto = 1'b1; goto_addr = 12'h100;
    tick(epc, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    goto = 1'b0;
    tick(epc, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

    // Overflow on the ninth call
    reset = 1'b0;
    tick(12'h000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    reset = 1'b1;
    tick(12'h001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    epc = 12'h001;
    do_calls();
    call = 1'b1; goto_addr = 12'h7FF;
    tick(epc, 1'b0, 1'b1, 1'b1, 4'd8, 1'b0);
    call = 1'b0; ret = 1'b1;
    tick(epc, 1'b0, 1'b1, 1'b1, 4'd8, 1'b0);
    ret = 1'b0;

    // Reset clears a full, errored stack; then underflow at depth 0
    reset = 1'b0;
    tick(12'h000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    reset = 1'b1;
    tick(12'h001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    ret = 1'b1;
    tick(12'h001, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    ret = 1'b0;
    tick(12'h001, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    reset = 1'b0;
    tick(12'h000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
